// File: rtl/armcpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : armcpu_pkg
// Purpose  : Shared widths, register indices, addressing-mode encoding and
//            sequencer state encoding for the LDM/STM transfer engine.
// Revision : 1.0 - initial release
// ============================================================================
package armcpu_pkg;

  localparam int WORD_SIZE  = 32;
  localparam int NUM_REGS   = 16;
  localparam int ADDR_WIDTH = 4;

  // r15 is the program counter
  localparam logic [ADDR_WIDTH-1:0] PC_IDX = 4'd15;

  // Addressing mode as {up, pre}
  typedef enum logic [1:0] {
    MODE_DA = 2'b00,
    MODE_DB = 2'b01,
    MODE_IA = 2'b10,
    MODE_IB = 2'b11
  } addr_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_WBACK = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/ldm_stm_sequencer_lsb.sv
`default_nettype none
// ============================================================================
// Module   : lowest_set_bit
// Purpose  : Combinational priority encoder (lowest set bit) plus popcount
//            over a register list.
// Revision : 1.0 - initial release
// ============================================================================
module lowest_set_bit
  import armcpu_pkg::*;
#(
  parameter int NUM_REGS   = armcpu_pkg::NUM_REGS,
  parameter int ADDR_WIDTH = armcpu_pkg::ADDR_WIDTH
) (
  input  logic [NUM_REGS-1:0]   vec,
  output logic [ADDR_WIDTH-1:0] idx,
  output logic [ADDR_WIDTH:0]   count
);

  // Scan high to low so the last hit written is the lowest set bit
  always_comb begin
    idx   = '0;
    count = '0;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = ADDR_WIDTH'(i);
      end
      count = count + (ADDR_WIDTH + 1)'(vec[i]);
    end
  end

endmodule
`default_nettype wire

// File: rtl/ldm_stm_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ldm_stm_sequencer
// Purpose  : LDM/STM multi-register transfer engine. Walks the register list
//            lowest-first, one memory beat per register, with optional base
//            writeback at the end of the instruction.
// Revision : 1.0 - initial release
// ============================================================================
module ldm_stm_sequencer #(
  parameter int WORD_SIZE       = armcpu_pkg::WORD_SIZE,
  parameter int NUM_REGS        = armcpu_pkg::NUM_REGS,
  parameter int ADDR_WIDTH      = armcpu_pkg::ADDR_WIDTH,
  parameter int PC_STORE_OFFSET = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  is_load,
  input  logic                  up,
  input  logic                  pre,
  input  logic                  wback,
  input  logic [ADDR_WIDTH-1:0] base_reg,
  input  logic [WORD_SIZE-1:0]  base_addr,
  input  logic [NUM_REGS-1:0]   reg_list,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [WORD_SIZE-1:0]  mem_addr,
  output logic [WORD_SIZE-1:0]  mem_wdata,
  input  logic [WORD_SIZE-1:0]  mem_rdata,
  input  logic                  mem_ready,
  output logic [ADDR_WIDTH-1:0] read_rn,
  input  logic [WORD_SIZE-1:0]  rn_out,
  input  logic [WORD_SIZE-1:0]  pc_out,
  output logic                  rd_we,
  output logic [ADDR_WIDTH-1:0] write_rd,
  output logic [WORD_SIZE-1:0]  rd_in,
  output logic                  pc_we,
  output logic [WORD_SIZE-1:0]  pc_in
);

  import armcpu_pkg::*;

  state_e                  state_q, state_d;
  logic [NUM_REGS-1:0]     list_q, list_d;
  logic [WORD_SIZE-1:0]    addr_q, addr_d;
  logic [WORD_SIZE-1:0]    final_q, final_d;
  logic                    is_load_q, is_load_d;
  logic                    wback_q, wback_d;
  logic                    base_in_list_q, base_in_list_d;
  logic [ADDR_WIDTH-1:0]   base_reg_q, base_reg_d;

  logic [NUM_REGS-1:0]     enc_vec;
  logic [ADDR_WIDTH-1:0]   enc_idx;
  logic [ADDR_WIDTH:0]     enc_cnt;
  logic [WORD_SIZE-1:0]    four_n;
  addr_mode_e              mode;

  // One encoder serves both the command decode (IDLE) and the list walk
  assign enc_vec = (state_q == ST_IDLE) ? reg_list : list_q;

  lowest_set_bit #(
    .NUM_REGS   (NUM_REGS),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_lsb (
    .vec   (enc_vec),
    .idx   (enc_idx),
    .count (enc_cnt)
  );

  assign four_n = {{(WORD_SIZE - ADDR_WIDTH - 3){1'b0}}, enc_cnt, 2'b00};
  assign mode   = addr_mode_e'({up, pre});

  // State and latched-command registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      list_q         <= '0;
      addr_q         <= '0;
      final_q        <= '0;
      is_load_q      <= 1'b0;
      wback_q        <= 1'b0;
      base_in_list_q <= 1'b0;
      base_reg_q     <= '0;
    end else begin
      state_q        <= state_d;
      list_q         <= list_d;
      addr_q         <= addr_d;
      final_q        <= final_d;
      is_load_q      <= is_load_d;
      wback_q        <= wback_d;
      base_in_list_q <= base_in_list_d;
      base_reg_q     <= base_reg_d;
    end
  end

  // Next-state, command latch and all port outputs
  always_comb begin
    state_d        = state_q;
    list_d         = list_q;
    addr_d         = addr_q;
    final_d        = final_q;
    is_load_d      = is_load_q;
    wback_d        = wback_q;
    base_in_list_d = base_in_list_q;
    base_reg_d     = base_reg_q;

    busy      = 1'b0;
    done      = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    read_rn   = '0;
    rd_we     = 1'b0;
    write_rd  = '0;
    rd_in     = '0;
    pc_we     = 1'b0;
    pc_in     = '0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          list_d         = reg_list;
          is_load_d      = is_load;
          wback_d        = wback;
          base_reg_d     = base_reg;
          base_in_list_d = reg_list[base_reg];
          case (mode)
            MODE_IA: addr_d = base_addr;
            MODE_IB: addr_d = base_addr + WORD_SIZE'(4);
            MODE_DA: addr_d = base_addr - four_n + WORD_SIZE'(4);
            default: addr_d = base_addr - four_n;
          endcase
          final_d = up ? (base_addr + four_n) : (base_addr - four_n);
          state_d = (enc_cnt != '0) ? ST_XFER : ST_DONE;
        end
      end

      ST_XFER: begin
        busy     = 1'b1;
        mem_req  = 1'b1;
        mem_we   = !is_load_q;
        mem_addr = addr_q;
        if (!is_load_q) begin
          read_rn   = enc_idx;
          // A stored PC reads ahead by the pipeline offset
          mem_wdata = (enc_idx == PC_IDX) ? (pc_out + WORD_SIZE'(PC_STORE_OFFSET)) : rn_out;
        end
        if (mem_ready) begin
          if (is_load_q) begin
            if (enc_idx == PC_IDX) begin
              pc_we = 1'b1;
              pc_in = mem_rdata & ~WORD_SIZE'(3);
            end else begin
              rd_we    = 1'b1;
              write_rd = enc_idx;
              rd_in    = mem_rdata;
            end
          end
          addr_d = addr_q + WORD_SIZE'(4);
          list_d = list_q & ~(NUM_REGS'(1) << enc_idx);
          if (enc_cnt == (ADDR_WIDTH + 1)'(1)) begin
            // A loaded base wins over writeback
            state_d = (wback_q && !(is_load_q && base_in_list_q)) ? ST_WBACK : ST_DONE;
          end
        end
      end

      ST_WBACK: begin
        busy     = 1'b1;
        rd_we    = 1'b1;
        write_rd = base_reg_q;
        rd_in    = final_q;
        state_d  = ST_DONE;
      end

      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_ldm_stm_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ldm_stm_sequencer
// Purpose  : Directed self-checking bench for ldm_stm_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ldm_stm_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, is_load, up, pre, wback;
  logic [3:0]  base_reg;
  logic [31:0] base_addr;
  logic [15:0] reg_list;
  logic        busy, done, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready;
  logic [3:0]  read_rn;
  logic [31:0] rn_out, pc_out;
  logic        rd_we;
  logic [3:0]  write_rd;
  logic [31:0] rd_in;
  logic        pc_we;
  logic [31:0] pc_in;

  logic [31:0] regs [16];
  int checks = 0;
  int errors = 0;

  assign rn_out = regs[read_rn];
  assign pc_out = 32'h0000_0500;

  always #5 clk = ~clk;

  ldm_stm_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .is_load(is_load), .up(up),
    .pre(pre), .wback(wback), .base_reg(base_reg), .base_addr(base_addr),
    .reg_list(reg_list), .busy(busy), .done(done), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .read_rn(read_rn),
    .rn_out(rn_out), .pc_out(pc_out), .rd_we(rd_we), .write_rd(write_rd),
    .rd_in(rd_in), .pc_we(pc_we), .pc_in(pc_in)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic ld, input logic u, input logic p, input logic wb,
                        input logic [3:0] br, input logic [31:0] ba, input logic [15:0] rl);
    is_load = ld; up = u; pre = p; wback = wb; base_reg = br; base_addr = ba; reg_list = rl;
    start = 1'b1;
    tick();
    start = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; is_load = 0; up = 0; pre = 0; wback = 0;
    base_reg = '0; base_addr = '0; reg_list = '0; mem_rdata = '0; mem_ready = 1'b1;
    for (int i = 0; i < 16; i++) regs[i] = 32'hDEAD_0000 + i;
    tick(); tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if ({mem_req, rd_we, pc_we, mem_we} !== 4'b0) begin errors++; $display("FAIL reset_strobes: got %b expected 0000", {mem_req, rd_we, pc_we, mem_we}); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", mem_addr); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_stmia();
    for (int i = 0; i < 4; i++) regs[i] = 32'd10 + i;
    mem_ready = 1'b1;
    launch(1'b0, 1'b1, 1'b0, 1'b0, 4'd9, 32'h100, 16'h000F);
    for (int k = 0; k < 4; k++) begin
      checks++; if ({busy, mem_req, mem_we} !== 3'b111) begin errors++; $display("FAIL stmia_req beat%0d: got %b expected 111", k, {busy, mem_req, mem_we}); end
      checks++; if (mem_addr !== 32'h100 + 4 * k) begin errors++; $display("FAIL stmia_addr beat%0d: got %h expected %h", k, mem_addr, 32'h100 + 4 * k); end
      checks++; if (mem_wdata !== 32'd10 + k) begin errors++; $display("FAIL stmia_wdata beat%0d: got %0d expected %0d", k, mem_wdata, 10 + k); end
      checks++; if (rd_we !== 1'b0) begin errors++; $display("FAIL stmia_no_rdwe beat%0d: got %b expected 0", k, rd_we); end
      tick();
    end
    checks++; if ({done, busy, mem_req} !== 3'b100) begin errors++; $display("FAIL stmia_done: got %b expected 100", {done, busy, mem_req}); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL stmia_done_pulse: got %b expected 0", done); end
  endtask

  task automatic test_ldmdb_wback();
    mem_ready = 1'b1;
    launch(1'b1, 1'b0, 1'b1, 1'b1, 4'd13, 32'h200, 16'h0030);
    mem_rdata = 32'hA4; #1;
    checks++; if ({mem_req, mem_we, mem_addr} !== {2'b10, 32'h1F8}) begin errors++; $display("FAIL ldmdb_beat0: got req/we %b addr %h expected 10 1f8", {mem_req, mem_we}, mem_addr); end
    checks++; if ({rd_we, write_rd, rd_in} !== {1'b1, 4'd4, 32'hA4}) begin errors++; $display("FAIL ldmdb_wr0: got %b r%0d %h expected 1 r4 a4", rd_we, write_rd, rd_in); end
    tick();
    mem_rdata = 32'hA5; #1;
    checks++; if (mem_addr !== 32'h1FC) begin errors++; $display("FAIL ldmdb_addr1: got %h expected 1fc", mem_addr); end
    checks++; if ({rd_we, write_rd, rd_in} !== {1'b1, 4'd5, 32'hA5}) begin errors++; $display("FAIL ldmdb_wr1: got %b r%0d %h expected 1 r5 a5", rd_we, write_rd, rd_in); end
    tick();
    checks++; if ({busy, mem_req, rd_we, write_rd, rd_in} !== {3'b101, 4'd13, 32'h1F8}) begin errors++; $display("FAIL ldmdb_wback: got busy/req/we %b r%0d %h expected 101 r13 1f8", {busy, mem_req, rd_we}, write_rd, rd_in); end
    tick();
    checks++; if ({done, rd_we} !== 2'b10) begin errors++; $display("FAIL ldmdb_done: got %b expected 10", {done, rd_we}); end
    tick();
  endtask

  task automatic test_ldmia_pc();
    mem_ready = 1'b1;
    launch(1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 32'h40, 16'h8001);
    mem_rdata = 32'd7; #1;
    checks++; if (mem_addr !== 32'h40) begin errors++; $display("FAIL ldmia_addr0: got %h expected 40", mem_addr); end
    checks++; if ({rd_we, write_rd, rd_in, pc_we} !== {1'b1, 4'd0, 32'd7, 1'b0}) begin errors++; $display("FAIL ldmia_r0: got we %b r%0d %h pc_we %b expected 1 r0 7 0", rd_we, write_rd, rd_in, pc_we); end
    tick();
    mem_rdata = 32'h1003; #1;
    checks++; if (mem_addr !== 32'h44) begin errors++; $display("FAIL ldmia_addr1: got %h expected 44", mem_addr); end
    checks++; if ({pc_we, pc_in, rd_we} !== {1'b1, 32'h1000, 1'b0}) begin errors++; $display("FAIL ldmia_pc: got pc_we %b pc_in %h rd_we %b expected 1 1000 0", pc_we, pc_in, rd_we); end
    tick();
    checks++; if ({done, rd_we, pc_we} !== 3'b100) begin errors++; $display("FAIL ldmia_done: got %b expected 100", {done, rd_we, pc_we}); end
    tick();
  endtask

  task automatic test_stall();
    regs[1] = 32'd11;
    mem_ready = 1'b0;
    launch(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 32'h0, 16'h0002);
    for (int k = 0; k < 3; k++) begin
      // A start pulse during the transfer must be ignored
      start = (k == 1); reg_list = 16'hFFFF; #1;
      checks++; if ({mem_req, mem_we, mem_addr, mem_wdata} !== {2'b11, 32'h4, 32'd11}) begin errors++; $display("FAIL stall_hold c%0d: got req/we %b addr %h wdata %h expected 11 4 b", k, {mem_req, mem_we}, mem_addr, mem_wdata); end
      tick();
    end
    start = 1'b0;
    mem_ready = 1'b1; #1;
    checks++; if ({mem_req, mem_addr, mem_wdata} !== {1'b1, 32'h4, 32'd11}) begin errors++; $display("FAIL stall_accept: got req %b addr %h wdata %h expected 1 4 b", mem_req, mem_addr, mem_wdata); end
    tick();
    checks++; if ({done, mem_req} !== 2'b10) begin errors++; $display("FAIL stall_done: got %b expected 10", {done, mem_req}); end
    tick();
    checks++; if ({busy, done, mem_req} !== 3'b000) begin errors++; $display("FAIL stall_idle: got %b expected 000", {busy, done, mem_req}); end
  endtask

  task automatic test_empty();
    mem_ready = 1'b1;
    launch(1'b1, 1'b1, 1'b0, 1'b1, 4'd3, 32'h80, 16'h0000);
    // Start cycle plus this one: done is in the second cycle of the command
    checks++; if ({done, busy, mem_req, rd_we} !== 4'b1000) begin errors++; $display("FAIL empty_done: got %b expected 1000", {done, busy, mem_req, rd_we}); end
    tick();
    checks++; if ({done, mem_req, rd_we} !== 3'b000) begin errors++; $display("FAIL empty_after: got %b expected 000", {done, mem_req, rd_we}); end
  endtask

  task automatic test_reset_mid();
    mem_ready = 1'b1;
    launch(1'b1, 1'b1, 1'b0, 1'b1, 4'd14, 32'h80, 16'h000F);
    mem_rdata = 32'h11; #1;
    checks++; if ({rd_we, write_rd, mem_addr} !== {1'b1, 4'd0, 32'h80}) begin errors++; $display("FAIL rmid_beat0: got we %b r%0d addr %h expected 1 r0 80", rd_we, write_rd, mem_addr); end
    tick();
    checks++; if (mem_addr !== 32'h84) begin errors++; $display("FAIL rmid_beat1_addr: got %h expected 84", mem_addr); end
    reset = 1'b0; #1;
    checks++; if ({busy, mem_req, rd_we, pc_we, mem_addr} !== {4'b0, 32'h0}) begin errors++; $display("FAIL rmid_abort: got %b addr %h expected 0000 0", {busy, mem_req, rd_we, pc_we}, mem_addr); end
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++; if ({mem_req, rd_we, done} !== 3'b000) begin errors++; $display("FAIL rmid_held c%0d: got %b expected 000", k, {mem_req, rd_we, done}); end
    end
    reset = 1'b1;
    tick();
    checks++; if ({busy, mem_req, rd_we} !== 3'b000) begin errors++; $display("FAIL rmid_no_resume: got %b expected 000", {busy, mem_req, rd_we}); end
    // Fresh STMDA of r15 with writeback to r2
    launch(1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 32'h300, 16'h8000);
    checks++; if ({mem_req, mem_we, mem_addr, mem_wdata} !== {2'b11, 32'h300, 32'h508}) begin errors++; $display("FAIL post_stm_pc: got %b addr %h wdata %h expected 11 300 508", {mem_req, mem_we}, mem_addr, mem_wdata); end
    tick();
    checks++; if ({rd_we, write_rd, rd_in} !== {1'b1, 4'd2, 32'h2FC}) begin errors++; $display("FAIL post_wback: got %b r%0d %h expected 1 r2 2fc", rd_we, write_rd, rd_in); end
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL post_done: got %b expected 1", done); end
    tick();
  endtask

  initial begin
    test_reset();
    test_stmia();
    test_ldmdb_wback();
    test_ldmia_pc();
    test_stall();
    test_empty();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  // Absolute time limit so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
